// File: rtl/pattern_misr_compactor.sv
`default_nettype none
// ============================================================================
// Module   : pattern_misr_compactor
// Brief    : Compacts circuit-under-test responses into a MISR and compares
//            the final signature against a golden value.
// Revision : 1.0
// ============================================================================
module pattern_misr_compactor #(
    parameter int                RESP_W = 9,
    parameter int                SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
    parameter int                CNT_W  = 16,
    parameter int                SKIP   = 2
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_beats,
    input  logic [SIG_W-1:0]  seed,
    input  logic [SIG_W-1:0]  golden,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  beats_seen,
    output logic              pass,
    output logic              fail
);

    localparam int                SKIP_W    = (SKIP < 2) ? 1 : $clog2(SKIP + 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_num_beats;
    logic [SIG_W-1:0]   r_golden;
    logic [SIG_W-1:0]   r_sig;
    logic [CNT_W-1:0]   r_beats;
    logic [SKIP_W-1:0]  r_skip;
    logic               r_pass;
    logic               r_fail;

    logic [SIG_W-1:0]   w_sig_next;
    logic [CNT_W-1:0]   w_beats_inc;
    logic               w_last_beat;

    // Shift left, fold the outgoing MSB back through the polynomial taps,
    // then merge the zero-extended response vector.
    assign w_sig_next  = {r_sig[SIG_W-2:0], 1'b0}
                       ^ (r_sig[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                       ^ SIG_W'(resp_in);
    assign w_beats_inc = r_beats + 1'b1;
    assign w_last_beat = resp_valid && (w_beats_inc == r_num_beats);

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (num_beats == '0) begin
                        w_state_next = ST_DONE;
                    end else if (SKIP == 0) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = ST_WARM;
                    end
                end
            end
            ST_WARM: begin
                if (resp_valid && (r_skip == SKIP_LAST)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_beat) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Verdict is registered on the transition into DONE so that it appears
    // in the same cycle as the done pulse.
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            r_num_beats <= '0;
            r_golden    <= '0;
            r_sig       <= '0;
            r_beats     <= '0;
            r_skip      <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_num_beats <= num_beats;
                        r_golden    <= golden;
                        r_sig       <= seed;
                        r_beats     <= '0;
                        r_skip      <= '0;
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                        if (num_beats == '0) begin
                            r_pass <= (seed == golden);
                            r_fail <= (seed != golden);
                        end
                    end
                end
                ST_WARM: begin
                    if (resp_valid) begin
                        r_skip <= r_skip + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (resp_valid) begin
                        r_sig   <= w_sig_next;
                        r_beats <= w_beats_inc;
                        if (w_last_beat) begin
                            r_pass <= (w_sig_next == r_golden);
                            r_fail <= (w_sig_next != r_golden);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (r_state == ST_WARM) || (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign signature  = r_sig;
    assign beats_seen = r_beats;
    assign pass       = r_pass;
    assign fail       = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_pattern_misr_compactor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_misr_compactor
// Brief    : Directed scoreboard bench for two compactors (SKIP=0, SKIP=2).
// Revision : 1.0
// ============================================================================
module tb_pattern_misr_compactor;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] beats;
        logic        pass;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_beats = '0;
    logic [15:0] seed = '0;
    logic [15:0] golden = '0;
    logic        resp_valid = 1'b0;
    logic [8:0]  resp_in = '0;

    logic        start_0, start_2, valid_0, valid_2;
    logic        busy_0, busy_2, done_0, done_2, pass_0, pass_2, fail_0, fail_2;
    logic [15:0] sig_0, sig_2, beats_0, beats_2;
    logic        busy, done, pass, fail;
    logic [15:0] signature, beats_seen;

    int checks = 0;
    int errors = 0;
    exp_t        sb[$];
    logic [8:0]  beat_q[$];

    always #5 clk = ~clk;

    assign start_0 = start && !sel;
    assign start_2 = start && sel;
    assign valid_0 = resp_valid && !sel;
    assign valid_2 = resp_valid && sel;
    assign busy       = sel ? busy_2  : busy_0;
    assign done       = sel ? done_2  : done_0;
    assign pass       = sel ? pass_2  : pass_0;
    assign fail       = sel ? fail_2  : fail_0;
    assign signature  = sel ? sig_2   : sig_0;
    assign beats_seen = sel ? beats_2 : beats_0;

    pattern_misr_compactor #(.SKIP(0)) u_dut0 (
        .blif_clk_net(clk), .blif_reset_net(rst), .start(start_0),
        .num_beats(num_beats), .seed(seed), .golden(golden),
        .resp_valid(valid_0), .resp_in(resp_in), .busy(busy_0), .done(done_0),
        .signature(sig_0), .beats_seen(beats_0), .pass(pass_0), .fail(fail_0)
    );

    pattern_misr_compactor #(.SKIP(2)) u_dut2 (
        .blif_clk_net(clk), .blif_reset_net(rst), .start(start_2),
        .num_beats(num_beats), .seed(seed), .golden(golden),
        .resp_valid(valid_2), .resp_in(resp_in), .busy(busy_2), .done(done_2),
        .signature(sig_2), .beats_seen(beats_2), .pass(pass_2), .fail(fail_2)
    );

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [8:0] r);
        logic [15:0] n;
        n = s << 1;
        if (s[15]) n = n ^ 16'h1021;
        return n ^ {7'b0, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done();
        int   waited;
        exp_t e;
        waited = 0;
        while (!done && waited < 4) begin
            tick();
            waited++;
        end
        check("done_latency", waited, 0);
        if (!done) begin
            check("done_timeout", 0, 1);
        end else if (sb.size() == 0) begin
            check("sb_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            check("sb_signature", signature, e.sig);
            check("sb_beats", beats_seen, e.beats);
            check("sb_pass", pass, e.pass);
            check("sb_fail", fail, !e.pass);
            check("busy_at_done", busy, 0);
        end
    endtask

    task automatic session(input bit s_sel, input logic [15:0] s_seed, input logic [15:0] nb,
                           input logic [15:0] gold, input bit gaps, input bit poke);
        exp_t e;
        int   skipn;
        logic held_pass;
        skipn   = s_sel ? 2 : 0;
        e.sig   = s_seed;
        e.beats = 0;
        foreach (beat_q[i]) begin
            if (i >= skipn && e.beats < nb) begin
                e.sig = misr_step(e.sig, beat_q[i]);
                e.beats++;
            end
        end
        e.pass = (e.sig == gold);
        sb.push_back(e);

        sel = s_sel; num_beats = nb; seed = s_seed; golden = gold; start = 1'b1;
        tick();
        start = 1'b0;
        check("seed_load", signature, s_seed);
        if (nb != 0) begin
            check("busy_after_start", busy, 1);
            check("beats_cleared", beats_seen, 0);
            check("verdict_cleared", {pass, fail}, 2'b00);
        end
        foreach (beat_q[i]) begin
            if (gaps) begin
                resp_valid = 1'b0;
                resp_in    = 9'h1FF;
                tick();
            end
            resp_valid = 1'b1;
            resp_in    = beat_q[i];
            tick();
            resp_valid = 1'b0;
            if (poke && i == 0) begin
                seed  = 16'hDEAD;
                start = 1'b1;
                tick();
                start = 1'b0;
                check("start_ignored_beats", beats_seen, 1);
                check("start_ignored_sig", signature, misr_step(s_seed, beat_q[0]));
            end
        end
        wait_done();
        held_pass = pass;
        tick();
        check("done_one_cycle", done, 0);
        check("pass_held", pass, held_pass);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {busy_0, busy_2}, 0);
        check("rst_done", {done_0, done_2}, 0);
        check("rst_sig", {sig_0, sig_2}, 0);
        check("rst_beats", {beats_0, beats_2}, 0);
        check("rst_verdict", {pass_0, fail_0, pass_2, fail_2}, 0);

        beat_q = '{9'h1FF};
        session(1'b0, 16'h0000, 16'd1, 16'h01FF, 1'b0, 1'b0);
        check("tp1_sig", signature, 16'h01FF);
        check("tp1_pass", {pass, fail}, 2'b10);

        beat_q = '{9'h1FF, 9'h000};
        session(1'b0, 16'h0000, 16'd2, 16'h03FF, 1'b0, 1'b0);
        check("tp2_sig", signature, 16'h03FE);
        check("tp2_fail", {pass, fail}, 2'b01);

        beat_q = '{9'h000};
        session(1'b0, 16'h8000, 16'd1, 16'h1021, 1'b0, 1'b0);
        check("tp3_feedback", signature, 16'h1021);

        beat_q = '{9'h0AA, 9'h055, 9'h001};
        session(1'b1, 16'h0000, 16'd1, 16'h0001, 1'b1, 1'b0);
        check("tp4_sig", signature, 16'h0001);
        check("tp4_beats", beats_seen, 16'd1);

        beat_q.delete();
        session(1'b0, 16'hABCD, 16'd0, 16'h0000, 1'b0, 1'b0);
        check("tp5_sig", signature, 16'hABCD);

        beat_q = '{9'h123, 9'h0F0, 9'h1A5};
        session(1'b0, 16'hC3C3, 16'd3, 16'h0000, 1'b0, 1'b1);

        sel = 1'b0; num_beats = 16'd5; seed = 16'h1234; golden = 16'h0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1;
            resp_in    = 9'(i + 7);
            tick();
        end
        resp_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", {busy, done, pass, fail, signature, beats_seen}, 0);
        tick();
        check("abort_no_done", done, 0);

        beat_q.delete();
        for (int i = 0; i < 6; i++) beat_q.push_back(9'($urandom_range(0, 511)));
        session(1'b1, 16'($urandom), 16'd4, 16'h5A5A, 1'b0, 1'b0);

        beat_q = '{9'h1FF, 9'h100};
        session(1'b0, 16'hFFFF, 16'd2, misr_step(misr_step(16'hFFFF, 9'h1FF), 9'h100), 1'b1, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
